// File: rtl/crop_filter_multi.sv
// crop_filter_multi
//   Cuts NUM_CROPS independent OUT_ROWS x OUT_COLS windows out of one
//   raster-order IN_ROWS x IN_COLS pixel stream in a single pass. Crops may
//   overlap. Each crop has its own AXI-stream output with TLAST.
//
//   Ports
//     clk, reset          clock, synchronous active-high reset
//     crop_coord_*        per-frame origin stream, {Y1, X1}, NUM_CROPS beats
//     pixel_in_*          input pixel stream, raster order
//     pixel_out_*         NUM_CROPS output channels, TDATA packed per channel
//     frame_done          1-cycle pulse once the frame and all outputs are done
//
//   crop_filter_lane holds one channel: its clamped origin, the window test
//   and the single-entry output register.

module crop_filter_lane #(
    parameter int PIXEL_BIT_WIDTH  = 16,
    parameter int OUT_ROWS         = 48,
    parameter int OUT_COLS         = 48,
    parameter int IMG_ROW_BITWIDTH = 10,
    parameter int IMG_COL_BITWIDTH = 10
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        coord_we,
    input  logic [IMG_ROW_BITWIDTH-1:0] y1_in,
    input  logic [IMG_COL_BITWIDTH-1:0] x1_in,
    input  logic [IMG_ROW_BITWIDTH-1:0] row,
    input  logic [IMG_COL_BITWIDTH-1:0] col,
    input  logic                        pix_accept,
    input  logic [PIXEL_BIT_WIDTH-1:0]  pix_data,
    input  logic                        out_ready,
    output logic                        blocked,
    output logic [PIXEL_BIT_WIDTH-1:0]  out_data,
    output logic                        out_valid,
    output logic                        out_last
);
    localparam int RW = IMG_ROW_BITWIDTH;
    localparam int CW = IMG_COL_BITWIDTH;
    localparam logic [RW:0] ROWS_W = (RW+1)'(OUT_ROWS);
    localparam logic [CW:0] COLS_W = (CW+1)'(OUT_COLS);

    logic [RW-1:0]              y1_q, y1_d;
    logic [CW-1:0]              x1_q, x1_d;
    logic [PIXEL_BIT_WIDTH-1:0] data_q, data_d;
    logic                       valid_q, valid_d;
    logic                       last_q, last_d;

    // Window ends computed one bit wider so y1+OUT_ROWS never wraps.
    logic [RW:0] row_end;
    logic [CW:0] col_end;
    logic        want, is_last, load;

    always_comb begin
        row_end = {1'b0, y1_q} + ROWS_W;
        col_end = {1'b0, x1_q} + COLS_W;
        want    = (row >= y1_q) && ({1'b0, row} < row_end) &&
                  (col >= x1_q) && ({1'b0, col} < col_end);
        is_last = ({1'b0, row} == row_end - (RW+1)'(1)) &&
                  ({1'b0, col} == col_end - (CW+1)'(1));
        load    = pix_accept && want;
        // Full register that is not draining this cycle stalls the input,
        // but only for pixels this channel actually wants.
        blocked = want && valid_q && !out_ready;

        y1_d    = y1_q;
        x1_d    = x1_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (coord_we) begin
            y1_d = y1_in;
            x1_d = x1_in;
        end
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
        // A reload in the same cycle as a drain wins: no bubble.
        if (load) begin
            valid_d = 1'b1;
            data_d  = pix_data;
            last_d  = is_last;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            y1_q    <= '0;
            x1_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            y1_q    <= y1_d;
            x1_q    <= x1_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
endmodule

module crop_filter_multi #(
    parameter int PIXEL_BIT_WIDTH  = 16,
    parameter int IN_ROWS          = 100,
    parameter int IN_COLS          = 160,
    parameter int OUT_ROWS         = 48,
    parameter int OUT_COLS         = 48,
    parameter int IMG_ROW_BITWIDTH = 10,
    parameter int IMG_COL_BITWIDTH = 10,
    parameter int NUM_CROPS        = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [IMG_ROW_BITWIDTH+IMG_COL_BITWIDTH-1:0] crop_coord_TDATA,
    input  logic                                   crop_coord_TVALID,
    output logic                                   crop_coord_TREADY,
    input  logic [PIXEL_BIT_WIDTH-1:0]             pixel_in_TDATA,
    input  logic                                   pixel_in_TVALID,
    output logic                                   pixel_in_TREADY,
    output logic [NUM_CROPS*PIXEL_BIT_WIDTH-1:0]   pixel_out_TDATA,
    output logic [NUM_CROPS-1:0]                   pixel_out_TVALID,
    input  logic [NUM_CROPS-1:0]                   pixel_out_TREADY,
    output logic [NUM_CROPS-1:0]                   pixel_out_TLAST,
    output logic                                   frame_done
);
    localparam int RW    = IMG_ROW_BITWIDTH;
    localparam int CW    = IMG_COL_BITWIDTH;
    localparam int IDX_W = $clog2(NUM_CROPS + 1);
    localparam logic [RW-1:0] Y_MAX    = RW'(IN_ROWS - OUT_ROWS);
    localparam logic [CW-1:0] X_MAX    = CW'(IN_COLS - OUT_COLS);
    localparam logic [RW-1:0] ROW_LAST = RW'(IN_ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IN_COLS - 1);

    typedef enum logic [1:0] {S_LOAD, S_STREAM, S_DRAIN} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [RW-1:0]    row_q, row_d;
    logic [CW-1:0]    col_q, col_d;
    logic             frame_done_q, frame_done_d;

    logic                 coord_hs, pix_accept;
    logic [RW-1:0]        y1_raw, y1_clamp;
    logic [CW-1:0]        x1_raw, x1_clamp;
    logic [NUM_CROPS-1:0] coord_we, blocked;

    // Origins are clamped once at load so the window never leaves the frame.
    assign y1_raw   = crop_coord_TDATA[RW+CW-1:CW];
    assign x1_raw   = crop_coord_TDATA[CW-1:0];
    assign y1_clamp = (y1_raw > Y_MAX) ? Y_MAX : y1_raw;
    assign x1_clamp = (x1_raw > X_MAX) ? X_MAX : x1_raw;

    assign crop_coord_TREADY = (state_q == S_LOAD);
    assign coord_hs          = crop_coord_TVALID && crop_coord_TREADY;
    assign pixel_in_TREADY   = (state_q == S_STREAM) && !(|blocked);
    assign pix_accept        = pixel_in_TVALID && pixel_in_TREADY;
    assign frame_done        = frame_done_q;

    for (genvar c = 0; c < NUM_CROPS; c++) begin : g_lane
        assign coord_we[c] = coord_hs && (idx_q == IDX_W'(c));

        crop_filter_lane #(
            .PIXEL_BIT_WIDTH  (PIXEL_BIT_WIDTH),
            .OUT_ROWS         (OUT_ROWS),
            .OUT_COLS         (OUT_COLS),
            .IMG_ROW_BITWIDTH (IMG_ROW_BITWIDTH),
            .IMG_COL_BITWIDTH (IMG_COL_BITWIDTH)
        ) u_lane (
            .clk        (clk),
            .reset      (reset),
            .coord_we   (coord_we[c]),
            .y1_in      (y1_clamp),
            .x1_in      (x1_clamp),
            .row        (row_q),
            .col        (col_q),
            .pix_accept (pix_accept),
            .pix_data   (pixel_in_TDATA),
            .out_ready  (pixel_out_TREADY[c]),
            .blocked    (blocked[c]),
            .out_data   (pixel_out_TDATA[c*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH]),
            .out_valid  (pixel_out_TVALID[c]),
            .out_last   (pixel_out_TLAST[c])
        );
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        row_d        = row_q;
        col_d        = col_q;
        frame_done_d = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (coord_hs) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(NUM_CROPS - 1)) state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (pix_accept) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            state_d = S_DRAIN;
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (!(|pixel_out_TVALID)) begin
                    frame_done_d = 1'b1;
                    state_d      = S_LOAD;
                    idx_d        = '0;
                    row_d        = '0;
                    col_d        = '0;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_LOAD;
            idx_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            row_q        <= row_d;
            col_q        <= col_d;
            frame_done_q <= frame_done_d;
        end
    end
endmodule

// File: tb/tb_crop_filter_multi.sv
// Bench for crop_filter_multi at default parameters (100x160 -> 48x48, 2 crops).
// Pixel value is the raster index. The model predicts beat n of channel c as
// the raster index of (Y1c + n/48, X1c + n%48), TLAST on beat 2303.

module tb_crop_filter_multi;
    localparam int PW    = 16;
    localparam int IR    = 100;
    localparam int IC    = 160;
    localparam int OR    = 48;
    localparam int OC    = 48;
    localparam int RW    = 10;
    localparam int CW    = 10;
    localparam int NC    = 2;
    localparam int BEATS = OR * OC;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [RW+CW-1:0]  crop_coord_TDATA = '0;
    logic              crop_coord_TVALID = 1'b0;
    logic              crop_coord_TREADY;
    logic [PW-1:0]     pixel_in_TDATA = '0;
    logic              pixel_in_TVALID = 1'b0;
    logic              pixel_in_TREADY;
    logic [NC*PW-1:0]  pixel_out_TDATA;
    logic [NC-1:0]     pixel_out_TVALID;
    logic [NC-1:0]     pixel_out_TREADY = '1;
    logic [NC-1:0]     pixel_out_TLAST;
    logic              frame_done;

    always #5 clk = ~clk;

    crop_filter_multi #(
        .PIXEL_BIT_WIDTH (PW), .IN_ROWS (IR), .IN_COLS (IC),
        .OUT_ROWS (OR), .OUT_COLS (OC),
        .IMG_ROW_BITWIDTH (RW), .IMG_COL_BITWIDTH (CW), .NUM_CROPS (NC)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .crop_coord_TDATA  (crop_coord_TDATA),
        .crop_coord_TVALID (crop_coord_TVALID),
        .crop_coord_TREADY (crop_coord_TREADY),
        .pixel_in_TDATA    (pixel_in_TDATA),
        .pixel_in_TVALID   (pixel_in_TVALID),
        .pixel_in_TREADY   (pixel_in_TREADY),
        .pixel_out_TDATA   (pixel_out_TDATA),
        .pixel_out_TVALID  (pixel_out_TVALID),
        .pixel_out_TREADY  (pixel_out_TREADY),
        .pixel_out_TLAST   (pixel_out_TLAST),
        .frame_done        (frame_done)
    );

    int n_vec = 0;
    int n_err = 0;

    // model state for the current frame
    int oy [NC];
    int ox [NC];
    int beat_n [NC];
    int first_v [NC];
    int last_v [NC];
    int last_cnt [NC];
    int fd_cnt = 0;
    int coord_cnt = 0;
    bit saw_1610 = 1'b0;
    int rdy_mode = 0;   // 0: all ready, 1: random, 2: ch1 held low

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_pix(input int c, input int n);
        return (oy[c] + n / OC) * IC + ox[c] + n % OC;
    endfunction

    function automatic int clampi(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // output ready generator
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: for (int c = 0; c < NC; c++) pixel_out_TREADY[c] = ($urandom_range(3) != 0);
            2: begin
                pixel_out_TREADY    = '1;
                pixel_out_TREADY[1] = 1'b0;
            end
            default: pixel_out_TREADY = '1;
        endcase
    end

    // compare process: every output handshake is checked against the model
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_done) fd_cnt++;
            if (crop_coord_TVALID && crop_coord_TREADY) coord_cnt++;
            if (pixel_out_TVALID == 2'b11 &&
                pixel_out_TDATA[PW-1:0] == PW'(1610) &&
                pixel_out_TDATA[2*PW-1:PW] == PW'(1610)) saw_1610 = 1'b1;
            for (int c = 0; c < NC; c++) begin
                if (pixel_out_TVALID[c] && pixel_out_TREADY[c]) begin
                    if (beat_n[c] >= BEATS) begin
                        chk($sformatf("ch%0d_extra_beat", c), beat_n[c] + 1, BEATS);
                    end else begin
                        chk($sformatf("ch%0d_beat%0d_data", c, beat_n[c]),
                            int'(pixel_out_TDATA[c*PW +: PW]), exp_pix(c, beat_n[c]));
                        chk($sformatf("ch%0d_beat%0d_last", c, beat_n[c]),
                            int'(pixel_out_TLAST[c]), (beat_n[c] == BEATS - 1) ? 1 : 0);
                    end
                    if (beat_n[c] == 0) first_v[c] = int'(pixel_out_TDATA[c*PW +: PW]);
                    if (pixel_out_TLAST[c]) begin
                        last_cnt[c]++;
                        last_v[c] = int'(pixel_out_TDATA[c*PW +: PW]);
                    end
                    beat_n[c]++;
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tvalid"}, int'(pixel_out_TVALID), 0);
        chk({tag, "_tlast"}, int'(pixel_out_TLAST), 0);
        chk({tag, "_tdata"}, int'(pixel_out_TDATA), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_coord_tready"}, int'(crop_coord_TREADY), 1);
        chk({tag, "_pixel_tready"}, int'(pixel_in_TREADY), 0);
    endtask

    task automatic send_coord(input int y, input int x, input bit rnd);
        bit acc = 1'b0;
        int g = 0;
        if (rnd && $urandom_range(1) == 1) tick();
        crop_coord_TDATA  = {RW'(y), CW'(x)};
        crop_coord_TVALID = 1'b1;
        while (!acc && g < 20) begin
            @(negedge clk);
            acc = crop_coord_TREADY;
            tick();
            g++;
        end
        crop_coord_TVALID = 1'b0;
        chk("coord_accepted", int'(acc), 1);
    endtask

    task automatic start_frame(input int y0, input int x0, input int y1, input int x1,
                               input bit rnd, input int mode);
        oy[0] = clampi(y0, IR - OR);
        ox[0] = clampi(x0, IC - OC);
        oy[1] = clampi(y1, IR - OR);
        ox[1] = clampi(x1, IC - OC);
        for (int c = 0; c < NC; c++) begin
            beat_n[c]   = 0;
            first_v[c]  = -1;
            last_v[c]   = -1;
            last_cnt[c] = 0;
        end
        fd_cnt    = 0;
        coord_cnt = 0;
        saw_1610  = 1'b0;
        rdy_mode  = mode;
        send_coord(y0, x0, rnd);
        send_coord(y1, x1, rnd);
        // surplus coordinate beat must be refused once streaming
        crop_coord_TDATA  = '1;
        crop_coord_TVALID = 1'b1;
        repeat (3) tick();
        crop_coord_TVALID = 1'b0;
    endtask

    task automatic stream(input int n_pix, input bit rnd, input bit bp);
        int idx = 0;
        int g = 0;
        int stall_at = -1;
        int held = 0;
        bit acc;
        while (idx < n_pix && g < n_pix * 4 + 2000) begin
            pixel_in_TVALID = rnd ? ($urandom_range(15) != 0) : 1'b1;
            pixel_in_TDATA  = PW'(idx);
            @(negedge clk);
            acc = pixel_in_TVALID && pixel_in_TREADY;
            if (bp && pixel_in_TVALID && !pixel_in_TREADY) begin
                if (stall_at < 0) stall_at = idx;
                held++;
                if (held == 40) rdy_mode = 0;
            end
            tick();
            if (acc) idx++;
            g++;
        end
        pixel_in_TVALID = 1'b0;
        chk("stream_pixels_accepted", idx, n_pix);
        // ch1 register fills with 8432; the next wanted pixel is the first stall
        if (bp) chk("bp_first_stalled_index", stall_at, 8433);
    endtask

    task automatic finish_frame(input string tag);
        int g = 0;
        while (fd_cnt == 0 && g < 500) begin
            tick();
            g++;
        end
        repeat (4) tick();
        chk({tag, "_frame_done_pulses"}, fd_cnt, 1);
        chk({tag, "_coord_beats"}, coord_cnt, NC);
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("%s_ch%0d_beats", tag, c), beat_n[c], BEATS);
            chk($sformatf("%s_ch%0d_tlast_count", tag, c), last_cnt[c], 1);
        end
    endtask

    task automatic report();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    endtask

    initial begin
        #990000;
        n_err++;
        $display("FAIL watchdog: cycle budget exhausted");
        report();
        $fatal(1, "watchdog");
    end

    initial begin
        for (int c = 0; c < NC; c++) begin
            oy[c] = 0; ox[c] = 0; beat_n[c] = 0;
            first_v[c] = -1; last_v[c] = -1; last_cnt[c] = 0;
        end
        reset = 1'b1;
        repeat (2) tick();
        check_reset_outputs("por");
        reset = 1'b0;

        // corner crops, everything ready
        start_frame(0, 0, 52, 112, 1'b0, 0);
        stream(IR * IC, 1'b0, 1'b0);
        finish_frame("f1");
        chk("f1_ch0_first", first_v[0], 0);
        chk("f1_ch0_last", last_v[0], 7567);
        chk("f1_ch1_first", first_v[1], 8432);
        chk("f1_ch1_last", last_v[1], 15999);

        // overlapping crops
        start_frame(0, 0, 10, 10, 1'b0, 0);
        stream(IR * IC, 1'b0, 1'b0);
        finish_frame("f2");
        chk("f2_1610_both_same_cycle", int'(saw_1610), 1);
        chk("f2_ch1_first", first_v[1], 1610);
        chk("f2_ch1_last", last_v[1], 9177);

        // out-of-range origin clamps to (52,112); ch1 held not-ready
        start_frame(0, 0, 80, 150, 1'b0, 2);
        stream(IR * IC, 1'b0, 1'b1);
        finish_frame("f3");
        chk("f3_ch0_last", last_v[0], 7567);
        chk("f3_ch1_first", first_v[1], 8432);
        chk("f3_ch1_last", last_v[1], 15999);

        // randomised valid/ready on every stream
        start_frame(30, 40, 2, 97, 1'b1, 1);
        stream(IR * IC, 1'b1, 1'b0);
        finish_frame("f4");
        chk("f4_ch0_first", first_v[0], 4840);
        chk("f4_ch0_last", last_v[0], 12407);
        chk("f4_ch1_first", first_v[1], 417);
        chk("f4_ch1_last", last_v[1], 7984);

        // reset in the middle of a frame, then rerun from scratch
        start_frame(5, 5, 20, 30, 1'b0, 0);
        stream(5000, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        check_reset_outputs("mid");
        reset = 1'b0;
        start_frame(0, 0, 0, 0, 1'b0, 0);
        stream(7568, 1'b0, 1'b0);
        repeat (5) tick();
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("f5_ch%0d_beats", c), beat_n[c], BEATS);
            chk($sformatf("f5_ch%0d_first", c), first_v[c], 0);
            chk($sformatf("f5_ch%0d_last", c), last_v[c], 7567);
            chk($sformatf("f5_ch%0d_tlast_count", c), last_cnt[c], 1);
        end

        report();
        $finish;
    end
endmodule
